// File: rtl/ex_muldiv_unit_pkg.sv
// Shared RV32M definitions: decoded instruction ids, FSM state encoding
// and small classification helpers used by the decoder, ID/EX and the EX unit.
package ex_muldiv_unit_pkg;

  localparam logic [5:0] INSTR_MUL    = 6'd32;
  localparam logic [5:0] INSTR_MULH   = 6'd33;
  localparam logic [5:0] INSTR_MULHSU = 6'd34;
  localparam logic [5:0] INSTR_MULHU  = 6'd35;
  localparam logic [5:0] INSTR_DIV    = 6'd36;
  localparam logic [5:0] INSTR_DIVU   = 6'd37;
  localparam logic [5:0] INSTR_REM    = 6'd38;
  localparam logic [5:0] INSTR_REMU   = 6'd39;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    MUL  = ST_MUL,
    DIV  = ST_DIV,
    DONE = ST_DONE
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] id);
    return id inside {INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU,
                      INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU};
  endfunction

  function automatic logic is_mul_op(input logic [5:0] id);
    return id inside {INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU};
  endfunction

  function automatic logic is_signed_div(input logic [5:0] id);
    return id inside {INSTR_DIV, INSTR_REM};
  endfunction

  function automatic logic is_rem_op(input logic [5:0] id);
    return id inside {INSTR_REM, INSTR_REMU};
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Bundle between the ID/EX stage / hazard logic (master) and the M-extension
// execute unit (slave).
interface ex_muldiv_unit_if;
  logic        valid_in;
  logic [5:0]  instr_id_in;
  logic [31:0] rs1_value_in;
  logic [31:0] rs2_value_in;
  logic [4:0]  rd_addr_in;
  logic        flush;
  logic        cache_stall;
  logic        stall_out;
  logic [31:0] result_out;
  logic        result_valid;
  logic [4:0]  rd_addr_out;
  logic        busy;

  modport master (
    output valid_in, instr_id_in, rs1_value_in, rs2_value_in, rd_addr_in,
           flush, cache_stall,
    input  stall_out, result_out, result_valid, rd_addr_out, busy
  );

  modport slave (
    input  valid_in, instr_id_in, rs1_value_in, rs2_value_in, rd_addr_in,
           flush, cache_stall,
    output stall_out, result_out, result_valid, rd_addr_out, busy
  );
endinterface

// File: rtl/ex_muldiv_unit_div_core.sv
// Iterative unsigned restoring divider retiring DIV_BITS_PER_CYCLE quotient
// bits per step; quotient/remainder show the value after the current step.
module muldiv_div_core #(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last
);
  localparam int N  = 32 / DIV_BITS_PER_CYCLE;
  localparam int CW = $clog2(N);

  logic [31:0]   rem_q, quo_q, dsr_q;
  logic [CW-1:0] cnt_q;
  logic [32:0]   trial;
  logic [31:0]   quo_n, rem_n;

  // The dividend shifts out of the quotient register as quotient bits shift in.
  always_comb begin
    trial = '0;
    quo_n = quo_q;
    rem_n = rem_q;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      trial = {rem_n, quo_n[31]};
      quo_n = {quo_n[30:0], 1'b0};
      if (trial >= {1'b0, dsr_q}) begin
        trial    = trial - {1'b0, dsr_q};
        quo_n[0] = 1'b1;
      end
      rem_n = trial[31:0];
    end
  end

  assign quotient  = quo_n;
  assign remainder = rem_n;
  assign last      = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= CW'(N - 1);
    end else if (step) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: 2-cycle registered multiply, iterative divide with
// fast paths for divide-by-zero and signed overflow, pipeline hold while busy.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            rst,
  ex_muldiv_unit_if.slave bus
);
  state_t      state;
  logic [5:0]  op;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  rd;
  logic        neg_quo, neg_rem;

  logic        start, mul_start, signed_div, div_zero, div_ovf;
  logic        div_load, div_step, div_last;
  logic [31:0] mag_a, mag_b, div_quo, div_rem, quo_fix, rem_fix;
  logic [63:0] wide_a, wide_b, product;

  assign start      = (state == IDLE) && bus.valid_in && is_muldiv(bus.instr_id_in) && !bus.flush;
  assign mul_start  = is_mul_op(bus.instr_id_in);
  assign signed_div = is_signed_div(bus.instr_id_in);
  assign div_zero   = (bus.rs2_value_in == '0);
  assign div_ovf    = signed_div && (bus.rs1_value_in == 32'h8000_0000)
                      && (bus.rs2_value_in == 32'hFFFF_FFFF);
  assign div_load   = start && !mul_start && !div_zero && !div_ovf;
  assign div_step   = (state == DIV) && !bus.flush;

  assign mag_a = (signed_div && bus.rs1_value_in[31]) ? -bus.rs1_value_in : bus.rs1_value_in;
  assign mag_b = (signed_div && bus.rs2_value_in[31]) ? -bus.rs2_value_in : bus.rs2_value_in;

  // 64-bit extension keeps the low 64 bits of the 33x33 signed product exact.
  assign wide_a  = {{32{op_a[31] && (op != INSTR_MULHU)}}, op_a};
  assign wide_b  = {{32{op_b[31] && ((op == INSTR_MUL) || (op == INSTR_MULH))}}, op_b};
  assign product = wide_a * wide_b;

  assign quo_fix = neg_quo ? -div_quo : div_quo;
  assign rem_fix = neg_rem ? -div_rem : div_rem;

  muldiv_div_core #(
    .DIV_BITS_PER_CYCLE(DIV_BITS_PER_CYCLE)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .step      (div_step),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last      (div_last)
  );

  assign bus.stall_out    = start || (state == MUL) || (state == DIV);
  assign bus.result_valid = (state == DONE) && !bus.flush;
  assign bus.result_out   = result;
  assign bus.rd_addr_out  = rd;
  assign bus.busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op      <= '0;
      op_a    <= '0;
      op_b    <= '0;
      rd      <= '0;
      result  <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          op      <= bus.instr_id_in;
          op_a    <= bus.rs1_value_in;
          op_b    <= bus.rs2_value_in;
          rd      <= bus.rd_addr_in;
          neg_quo <= signed_div && (bus.rs1_value_in[31] ^ bus.rs2_value_in[31]);
          neg_rem <= signed_div && bus.rs1_value_in[31];
          if (mul_start) begin
            state <= MUL;
          end else if (div_zero) begin
            result <= is_rem_op(bus.instr_id_in) ? bus.rs1_value_in : 32'hFFFF_FFFF;
            state  <= DONE;
          end else if (div_ovf) begin
            result <= is_rem_op(bus.instr_id_in) ? 32'h0 : 32'h8000_0000;
            state  <= DONE;
          end else begin
            state <= DIV;
          end
        end
        MUL: begin
          result <= (op == INSTR_MUL) ? product[31:0] : product[63:32];
          state  <= DONE;
        end
        DIV: if (div_last) begin
          result <= is_rem_op(op) ? rem_fix : quo_fix;
          state  <= DONE;
        end
        DONE: if (!bus.cache_stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random
// M-extension ops compared against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int BITS      = 1;
  localparam int DIV_LAT   = 32 / BITS + 1;
  localparam int MAX_WAIT  = 80;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_muldiv_unit_if bus ();

  ex_muldiv_unit #(
    .DIV_BITS_PER_CYCLE(BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] refResult(input logic [5:0] id, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    p  = '0;
    case (id)
      INSTR_MUL:    begin p = sx * sy; return p[31:0];  end
      INSTR_MULH:   begin p = sx * sy; return p[63:32]; end
      INSTR_MULHSU: begin p = sx * uy; return p[63:32]; end
      INSTR_MULHU:  begin p = ux * uy; return p[63:32]; end
      // 64-bit arithmetic makes -2^31 / -1 wrap to 0x80000000 rem 0 naturally
      INSTR_DIV:    begin if (y == 0) return 32'hFFFF_FFFF; p = sx / sy; return p[31:0]; end
      INSTR_DIVU:   begin if (y == 0) return 32'hFFFF_FFFF; p = ux / uy; return p[31:0]; end
      INSTR_REM:    begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
      INSTR_REMU:   begin if (y == 0) return x; p = ux % uy; return p[31:0]; end
      default:      return '0;
    endcase
  endfunction

  function automatic int refLatency(input logic [5:0] id, input logic [31:0] x, input logic [31:0] y);
    if (id inside {INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU}) return 2;
    if (y == 0) return 1;
    if ((id inside {INSTR_DIV, INSTR_REM}) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return DIV_LAT;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_stall"}, 32'(bus.stall_out), 32'd0);
    checkOutput({tag, "_valid"}, 32'(bus.result_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic driveOp(input logic [5:0] id, input logic [31:0] x, input logic [31:0] y, input logic [4:0] rd);
    bus.valid_in     = 1'b1;
    bus.instr_id_in  = id;
    bus.rs1_value_in = x;
    bus.rs2_value_in = y;
    bus.rd_addr_in   = rd;
  endtask

  // Issues one op, measures latency and stall, checks result and the DONE hold.
  task automatic applyStimulus(input string tag, input logic [5:0] id, input logic [31:0] x,
                               input logic [31:0] y, input logic [4:0] rd, input int hold);
    logic [31:0] expRes, held;
    int expLat, cycles, stalls;
    expRes = refResult(id, x, y);
    expLat = refLatency(id, x, y);
    @(negedge clk);
    driveOp(id, x, y, rd);
    #1;
    cycles = 0;
    stalls = 0;
    while (!bus.result_valid && cycles < MAX_WAIT) begin
      if (bus.stall_out) stalls++;
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, "_stall_cycles"}, 32'(stalls), 32'(expLat));
    checkOutput({tag, "_result"}, bus.result_out, expRes);
    checkOutput({tag, "_rd"}, 32'(bus.rd_addr_out), 32'(rd));
    checkOutput({tag, "_done_stall"}, 32'(bus.stall_out), 32'd0);
    bus.valid_in = 1'b0;
    held = bus.result_out;
    if (hold > 0) bus.cache_stall = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_held_valid"}, 32'(bus.result_valid), 32'd1);
      checkOutput({tag, "_held_result"}, bus.result_out, held);
      if (k == hold) bus.cache_stall = 1'b0;
    end
    @(posedge clk);
    #1;
    checkIdleOutputs({tag, "_exit"});
  endtask

  initial begin
    logic [5:0]  rid;
    logic [31:0] rx, ry;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.instr_id_in = '0;
    bus.rs1_value_in = '0;
    bus.rs2_value_in = '0;
    bus.rd_addr_in = '0;
    bus.flush = 1'b0;
    bus.cache_stall = 1'b0;
    #2;
    checkIdleOutputs("reset");
    checkOutput("reset_result", bus.result_out, 32'd0);
    checkOutput("reset_rd", 32'(bus.rd_addr_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("mul_7x-3", INSTR_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 0);
    applyStimulus("mulh_min", INSTR_MULH, 32'h8000_0000, 32'h8000_0000, 5'd2, 0);
    applyStimulus("mulhu_max", INSTR_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    applyStimulus("mulhsu_neg", INSTR_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd4, 0);
    applyStimulus("div_-20_3", INSTR_DIV, 32'hFFFF_FFEC, 32'd3, 5'd5, 0);
    applyStimulus("rem_-20_3", INSTR_REM, 32'hFFFF_FFEC, 32'd3, 5'd6, 0);
    applyStimulus("divu_100_7", INSTR_DIVU, 32'd100, 32'd7, 5'd7, 0);
    applyStimulus("divu_by0", INSTR_DIVU, 32'd5, 32'd0, 5'd8, 0);
    applyStimulus("rem_by0", INSTR_REM, 32'd5, 32'd0, 5'd9, 0);
    applyStimulus("div_ovf", INSTR_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
    applyStimulus("rem_ovf", INSTR_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    applyStimulus("remu_big", INSTR_REMU, 32'hFFFF_FFFF, 32'h0001_0003, 5'd12, 0);
    applyStimulus("cache_hold", INSTR_DIV, 32'd1000, 32'hFFFF_FFF9, 5'd13, 4);

    // Non-M instruction and flush-vs-start must not start the unit
    @(negedge clk);
    driveOp(6'd3, 32'd1, 32'd2, 5'd14);
    #1;
    checkOutput("nonm_stall", 32'(bus.stall_out), 32'd0);
    @(posedge clk);
    #1;
    checkIdleOutputs("nonm_next");
    @(negedge clk);
    driveOp(INSTR_MUL, 32'd3, 32'd4, 5'd15);
    bus.flush = 1'b1;
    #1;
    checkOutput("flush_start_stall", 32'(bus.stall_out), 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.valid_in = 1'b0;
    checkIdleOutputs("flush_start_next");

    // Flush a divide around iteration 10
    @(negedge clk);
    driveOp(INSTR_DIV, 32'd123456, 32'd789, 5'd16);
    repeat (11) @(posedge clk);
    #1;
    checkOutput("div_inflight_busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    checkOutput("div_flush_valid", 32'(bus.result_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checkIdleOutputs("div_flushed");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput("div_flushed_quiet", 32'(bus.result_valid), 32'd0);
    end
    applyStimulus("mul_after_flush", INSTR_MUL, 32'd12345, 32'd678, 5'd17, 0);

    // Flush while in DONE kills result_valid in the same cycle
    @(negedge clk);
    driveOp(INSTR_DIVU, 32'd9, 32'd0, 5'd18);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    checkOutput("done_flush_pre", 32'(bus.result_valid), 32'd1);
    bus.flush = 1'b1;
    #1;
    checkOutput("done_flush_valid", 32'(bus.result_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    checkIdleOutputs("done_flushed");

    // Random ops against the reference model
    for (int n = 0; n < 24; n++) begin
      rid = INSTR_MUL + 6'($urandom_range(0, 7));
      rx  = $urandom;
      case ($urandom_range(0, 7))
        0:       ry = 32'd0;
        1, 2:    ry = 32'($urandom_range(1, 40));
        3:       ry = -32'($urandom_range(1, 40));
        default: ry = $urandom;
      endcase
      applyStimulus("random", rid, rx, ry, 5'($urandom_range(1, 31)), 0);
    end

    // Reset in the middle of a divide clears everything at once
    @(negedge clk);
    driveOp(INSTR_REM, 32'hDEAD_BEEF, 32'd77, 5'd19);
    repeat (6) @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    rst = 1'b1;
    #1;
    checkIdleOutputs("midreset");
    checkOutput("midreset_result", bus.result_out, 32'd0);
    checkOutput("midreset_rd", 32'(bus.rd_addr_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("after_reset", INSTR_DIVU, 32'd1000, 32'd10, 5'd20, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- RV32M execute-side unit, directly downstream of the ID/EX pipeline register; consumes its valid, instr_id, rd_addr and forwarded operand outputs.
- Performs MUL/MULH/MULHSU/MULHU as a 2-cycle registered multiply and DIV/DIVU/REM/REMU as an iterative restoring divide.
- Requests a pipeline hold while busy and presents a one-cycle-qualified result to the EX result mux / EX_MEM register.

Parameters:
- DIV_BITS_PER_CYCLE, 1, quotient bits retired per divide iteration; legal values 1 or 2; iteration count N = 32/DIV_BITS_PER_CYCLE.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- valid_in  input  1  ID/EX slot holds a live instruction
- instr_id_in  input  6  decoded instruction id; unit acts only on the eight M-extension ids
- rs1_value_in  input  32  forwarded rs1 operand
- rs2_value_in  input  32  forwarded rs2 operand
- rd_addr_in  input  5  destination register
- flush  input  1  branch/jump flush of the EX slot
- cache_stall  input  1  global memory stall; pipeline frozen
- stall_out  output  1  hold IF/ID and ID/EX; no bubble insertion
- result_out  output  32  M-extension result
- result_valid  output  1  result_out and rd_addr_out are valid this cycle
- rd_addr_out  output  5  destination of result_out
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset: async to IDLE. result_out=0, result_valid=0, rd_addr_out=0, busy=0, stall_out=0, and all internal operand, remainder, quotient and counter registers are 0.
- Start condition: start = IDLE & valid_in & is_muldiv(instr_id_in) & !flush.
- On start, latch both operands, the op and rd_addr_in.
- stall_out is combinational: start | state==MUL | state==DIV. It is low in DONE, so the instruction leaves EX on the DONE clock edge.
- While stall_out is high, the pipeline holds ID/EX inputs stable. The unit does not depend on this, because its operands are already latched.
- IDLE -> MUL on a start with a multiply op.
- IDLE -> DIV on a start with a divide op, except for the special cases below.
- IDLE -> DONE directly for divide-by-zero and signed overflow (fast path).
- Divide-by-zero result: quotient=32'hFFFFFFFF; remainder=dividend. Applies to both signed and unsigned ops.
- Signed overflow (DIV/REM with rs1=32'h80000000 and rs2=32'hFFFFFFFF): quotient=32'h80000000; remainder=0.
- MUL state: one cycle. Registered 33x33 signed product, with operands sign- or zero-extended per op. MUL selects bits [31:0]; MULH/MULHSU/MULHU select bits [63:32]. Then -> DONE.
- DIV state: divide on operand magnitudes; counter runs N-1 down to 0. At counter 0, apply sign correction and go to DONE.
- DIV sign correction: quotient negated if the operand signs differ; remainder takes the dividend's sign.
- DONE state: result_valid=1, with result_out and rd_addr_out driven from registers. Go to IDLE unless cache_stall=1.
- While cache_stall holds DONE, result_valid stays asserted and the result stays stable.
- The unit never starts in DONE, because the same instruction is still in EX.
- Latency, counted from the start cycle to the DONE cycle:
  - multiply: 2 cycles (stall_out high 2 cycles)
  - divide: N+1 cycles (33 cycles at DIV_BITS_PER_CYCLE=1)
  - fast-path divide: 1 cycle
- cache_stall in MUL or DIV: computation continues. Only the exit from DONE waits.
- flush: highest priority below rst. From any state the next state is IDLE, result_valid is forced to 0 in that same cycle, and no writeback occurs.
- A flush in the same cycle as a candidate start suppresses the start.
- Non-M instructions and valid_in=0 in IDLE: no effect; stall_out=0; result_valid=0.
- Back-to-back M ops: the second op starts in the IDLE cycle that follows DONE. There is exactly one non-stalled gap cycle between the two ops.
- Register writeback from the unit occurs only for rd≠0.

Decomposition:
- Shared package (used by the decoder and ID/EX):
  - instr_id constants INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU, INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU
  - localparam state encoding IDLE/MUL/DIV/DONE
  - is_muldiv helper function
- One sub-module, muldiv_div_core: the iterative unsigned restoring divider (load, step, count, done), parameterised by DIV_BITS_PER_CYCLE. FSM, multiplier, sign handling and the special cases stay in the top.

Test Plan:
- MUL 7 × -3 -> result_out=32'hFFFFFFEB on the 3rd cycle from start; stall_out high exactly 2 cycles.
- MULH 32'h80000000 × 32'h80000000 -> 32'h40000000; MULHU 32'hFFFFFFFF × 32'hFFFFFFFF -> 32'hFFFFFFFE; MULHSU 32'hFFFFFFFF × 2 -> 32'hFFFFFFFF.
- DIV -20 / 3 -> 32'hFFFFFFFA, and REM -20 / 3 -> 32'hFFFFFFFE, each after 33 cycles; DIVU 100 / 7 -> 14.
- DIVU 5 / 0 -> 32'hFFFFFFFF; REM 5 / 0 -> 5; DIV 32'h80000000 / -1 -> 32'h80000000 with REM 0; each fast path gives stall_out for 1 cycle.
- DIV in flight, flush at iteration 10 -> IDLE next cycle, no result_valid; a following MUL starts cleanly and gives the correct result.
- cache_stall asserted for 4 cycles while in DONE -> result_valid held for 5 cycles with a stable value. Separately, rst asserted mid-divide -> all outputs 0 immediately.
